// File: rtl/uart_rx_frame_if.sv
// Serial-line interface for the 8N1 UART receiver.
// The slave modport is the receiver side. The master modport is the side that
// drives the line and consumes the received bytes.
interface uart_rx_frame_if;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Framing_Err;
  logic       o_Rx_Active;

  modport slave (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Framing_Err,
    output o_Rx_Active
  );

  modport master (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Framing_Err,
    input  o_Rx_Active
  );
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver, LSB first.
// A two-flop synchroniser feeds a single registered FSM. The FSM finds the
// middle of the start bit, then samples every data bit and the stop bit one
// bit period apart. A valid byte raises a one-cycle DV strobe, and a stop bit
// sampled low raises a one-cycle framing-error strobe.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  uart_rx_frame_if.slave  bus
);

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RX_START_BIT = 3'd1,
    RX_DATA_BITS = 3'd2,
    RX_STOP_BIT  = 3'd3,
    CLEANUP      = 3'd4
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic [15:0] clock_count;
  logic [2:0]  bit_index;
  logic [7:0]  rx_byte;
  logic        rx_dv;
  logic        framing_err;
  logic        rx_active;

  // Bring the asynchronous line into the clock domain. Both stages reset to
  // the idle level so that reset never looks like a start bit.
  always_ff @(posedge i_Clock) begin
    // NOTE: registers use non-blocking assignment, so every stage captures the
    // value from before the clock edge. This makes a real two-stage pipeline.
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with counters, data register and registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      clock_count <= '0;
      bit_index   <= '0;
      rx_byte     <= '0;
      rx_dv       <= 1'b0;
      framing_err <= 1'b0;
      rx_active   <= 1'b0;
    end else begin
      // The strobes last one cycle. Only the stop-bit sample raises them.
      rx_dv       <= 1'b0;
      framing_err <= 1'b0;
      case (state)
        IDLE: begin
          clock_count <= '0;
          bit_index   <= '0;
          if (rx_s == 1'b0) begin
            state     <= RX_START_BIT;
            rx_active <= 1'b1;
          end else begin
            rx_active <= 1'b0;
          end
        end

        RX_START_BIT: begin
          if (clock_count != HALF) begin
            clock_count <= clock_count + 16'd1;
          end else if (rx_s == 1'b0) begin
            clock_count <= '0;
            state       <= RX_DATA_BITS;
          end else begin
            // The line went high before mid-bit, so treat it as a glitch.
            state     <= IDLE;
            rx_active <= 1'b0;
          end
        end

        RX_DATA_BITS: begin
          if (clock_count != LAST) begin
            clock_count <= clock_count + 16'd1;
          end else begin
            clock_count        <= '0;
            rx_byte[bit_index] <= rx_s;
            if (bit_index != 3'd7) begin
              bit_index <= bit_index + 3'd1;
            end else begin
              bit_index <= '0;
              state     <= RX_STOP_BIT;
            end
          end
        end

        RX_STOP_BIT: begin
          if (clock_count != LAST) begin
            clock_count <= clock_count + 16'd1;
          end else begin
            // Leave at mid-stop-bit. This gives back-to-back frames half a bit
            // of slack to see the next start edge.
            clock_count <= '0;
            state       <= CLEANUP;
            rx_active   <= 1'b0;
            if (rx_s == 1'b1) rx_dv       <= 1'b1;
            else              framing_err <= 1'b1;
          end
        end

        CLEANUP: begin
          state     <= IDLE;
          rx_active <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          clock_count <= '0;
          bit_index   <= '0;
          rx_active   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_Rx_DV       = rx_dv;
  assign bus.o_Rx_Byte     = rx_byte;
  assign bus.o_Framing_Err = framing_err;
  assign bus.o_Rx_Active   = rx_active;

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- 8N1 UART receiver, LSB first; the receive-side counterpart of the UART transmitter datapath.
- Synchronises the asynchronous serial line and detects the start bit.
- Samples each data bit and the stop bit at mid-bit, using a clock counter and a bit index like the TX side.
- Delivers the received byte with a one-cycle valid strobe, plus a framing-error strobe.

Parameters:
- CLKS_PER_BIT, 5208, system clocks per bit (50 MHz / 9600 baud). Legal range 4..65535.

Ports:
- i_Clock  input  1  system clock; all state updates on rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Rx_Serial  input  1  asynchronous serial line; idle level 1.
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a valid frame.
- o_Rx_Byte  output  8  received byte; bit n = nth data bit received.
- o_Framing_Err  output  1  one-cycle pulse: stop bit sampled as 0.
- o_Rx_Active  output  1  high while a frame is being received.

Behaviour:
- Synchroniser:
  - Two flip-flops on i_Rx_Serial, both reset to 1.
  - The FSM sees only the second stage (rx_s).
- Counters:
  - clock_count: 16 bits, increments by 1.
  - bit_index: 3 bits, zero-extended compares.
  - H = (CLKS_PER_BIT-1)/2, integer division.
- FSM states, 3-bit encoding: IDLE=0, RX_START_BIT=1, RX_DATA_BITS=2, RX_STOP_BIT=3, CLEANUP=4. Codes 5..7 go to IDLE on the next edge.
- IDLE:
  - clock_count=0, bit_index=0.
  - If rx_s==0, go to RX_START_BIT.
- RX_START_BIT:
  - If clock_count!=H: clock_count++.
  - Else if rx_s==0: clock_count=0 and go to RX_DATA_BITS.
  - Else (glitch): go to IDLE, no strobe.
- RX_DATA_BITS:
  - If clock_count!=CLKS_PER_BIT-1: clock_count++.
  - Else: o_Rx_Byte[bit_index]=rx_s and clock_count=0.
    - If bit_index<7: bit_index++.
    - Else: bit_index=0 and go to RX_STOP_BIT.
- RX_STOP_BIT:
  - If clock_count!=CLKS_PER_BIT-1: clock_count++.
  - Else: clock_count=0 and go to CLEANUP.
    - If rx_s==1, assert o_Rx_DV for the following cycle.
    - Otherwise assert o_Framing_Err for the following cycle.
- CLEANUP:
  - Stays exactly 1 cycle, then goes to IDLE.
  - o_Rx_DV and o_Framing_Err return to 0 in this cycle.
- o_Rx_Active = 1 in RX_START_BIT, RX_DATA_BITS and RX_STOP_BIT; registered from the state.
- Strobes are registered; DV and Framing_Err are never high together.
- o_Rx_Byte:
  - Updates bit-by-bit during reception.
  - Holds its last value after the frame.
  - Is meaningful only while o_Rx_DV is high.
- Timing: let E be the edge at which sync stage 1 first captures 0.
  - START is entered at edge E+2.
  - Bit k is sampled at edge E+3+H+(k+1)*CLKS_PER_BIT.
  - o_Rx_DV is high for the cycle after edge E+3+H+9*CLKS_PER_BIT.
- Back-to-back frames: IDLE is re-entered about half a bit before the stop bit ends, so a start bit immediately after the stop bit is received correctly.
- A break condition (line held at 0) produces a framing error, then a new frame attempt immediately after CLEANUP.
- Reset, at any time including mid-frame:
  - State=IDLE, clock_count=0, bit_index=0.
  - o_Rx_Byte=0x00, o_Rx_DV=0, o_Framing_Err=0, o_Rx_Active=0.
  - Sync flip-flops=1.
  - An aborted frame produces no strobe.
- Reset wins over every other event in the same cycle.

Test Plan:
- Reset behaviour: CLKS_PER_BIT=8; hold reset 3 cycles with the line at 1 -> all outputs 0, o_Rx_Active=0, no strobes for 200 idle cycles.
- Single frame: CLKS_PER_BIT=8; send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop=1) -> o_Rx_DV high for exactly 1 cycle, at edge E+78; o_Rx_Byte=0xA5; o_Framing_Err=0.
- Back-to-back frames: send 0x00, 0xFF and 0x3C with no idle gap -> three DV pulses exactly 80 cycles apart, bytes in order, no errors.
- Framing error: send 0x5A with stop bit=0 -> o_Framing_Err pulses once, o_Rx_DV stays 0; a following 0x11 with a correct stop bit is received correctly.
- Glitch rejection: line at 0 for 2 cycles (shorter than H+1 cycles) then 1 -> FSM returns to IDLE, no strobes, o_Rx_Active high for at most H+2 cycles.
- Reset mid-frame: assert reset after bit 3 of 0xC3 -> outputs 0 and state IDLE on the next edge, no DV; the next full frame 0x7E is received correctly.
